guess_engine: RTL and testbench

//  Parametrised letter-guess engine for the Hangman game: holds the secret word, checks each

---
 rtl/hangman_pkg.sv | 17 +
 rtl/guess_engine_slot_match.sv | 21 ++
 rtl/guess_engine.sv | 184 ++++++++++++++++++
 tb/tb_guess_engine.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and FSM state encoding for the Hangman guess engine.
package hangman_pkg;

   localparam int          LETTER_W    = 5;
   localparam logic [4:0]  BLANK       = 5'b11111;
   localparam int          LETTER_MAX  = 25;
   localparam int          NUM_LETTERS = 26;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READY   = 3'd1,
      S_CHECK   = 3'd2,
      S_RELEASE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/guess_engine_slot_match.sv
// Parallel comparator: flags every active slot whose letter equals the guess.
module slot_match
   import hangman_pkg::*;
#(
   parameter int MAX_LEN  = 5,
   parameter int LETTER_W = 5
) (
   input  logic [MAX_LEN*LETTER_W-1:0] word,
   input  logic [MAX_LEN-1:0]          active,
   input  logic [LETTER_W-1:0]         g,
   output logic [MAX_LEN-1:0]          match
);

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_slot
         assign match[gi] = active[gi] & (word[gi*LETTER_W +: LETTER_W] == g);
      end
   endgenerate

endmodule

// File: rtl/guess_engine.sv
// Hangman letter-guess engine: secret word, revealed mask, used-letter set,
// saturating miss counter and win/loss flags behind a small guess FSM.
module guess_engine #(
   parameter  int MAX_LEN    = 5,
   parameter  int LETTER_W   = 5,
   parameter  int MAX_MISSES = 6,
   localparam int MISS_W     = $clog2(MAX_MISSES + 1)
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic [MAX_LEN*LETTER_W-1:0] word_in,
   input  logic                        go,
   input  logic [LETTER_W-1:0]         guess,
   output logic [MAX_LEN-1:0]          revealed,
   output logic [MAX_LEN-1:0]          active,
   output logic [MISS_W-1:0]           misses,
   output logic                        hit,
   output logic                        miss,
   output logic                        dup,
   output logic                        invalid,
   output logic                        won,
   output logic                        lost,
   output logic                        ready
);

   import hangman_pkg::*;

   localparam logic [LETTER_W-1:0] BLANK_CODE = {LETTER_W{1'b1}};
   localparam logic [LETTER_W-1:0] LAST_CODE  = LETTER_W'(LETTER_MAX);
   localparam logic [MISS_W-1:0]   MISS_LIMIT = MISS_W'(MAX_MISSES);
   localparam logic [MISS_W-1:0]   MISS_ONE   = MISS_W'(1);

   state_t                         state_q, state_d;
   logic [MAX_LEN*LETTER_W-1:0]    word_q, word_d;
   logic [MAX_LEN-1:0]             active_q, active_d;
   logic [MAX_LEN-1:0]             revealed_q, revealed_d;
   logic [NUM_LETTERS-1:0]         used_q, used_d;
   logic [MISS_W-1:0]              misses_q, misses_d;
   logic [LETTER_W-1:0]            g_q, g_d;
   logic                           go_q, go_d;
   logic [LETTER_W-1:0]            guess_q, guess_d;
   logic                           hit_q, hit_d;
   logic                           miss_q, miss_d;
   logic                           dup_q, dup_d;
   logic                           invalid_q, invalid_d;
   logic                           won_q, won_d;
   logic                           lost_q, lost_d;

   logic [MAX_LEN-1:0]             word_active;
   logic [MAX_LEN-1:0]             match;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_active
         assign word_active[gi] = (word_in[gi*LETTER_W +: LETTER_W] != BLANK_CODE);
      end
   endgenerate

   slot_match #(
      .MAX_LEN  (MAX_LEN),
      .LETTER_W (LETTER_W)
   ) u_slot_match (
      .word   (word_q),
      .active (active_q),
      .g      (g_q),
      .match  (match)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         word_q     <= {MAX_LEN{BLANK_CODE}};
         active_q   <= '0;
         revealed_q <= '0;
         used_q     <= '0;
         misses_q   <= '0;
         g_q        <= '0;
         go_q       <= 1'b0;
         guess_q    <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         dup_q      <= 1'b0;
         invalid_q  <= 1'b0;
         won_q      <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         active_q   <= active_d;
         revealed_q <= revealed_d;
         used_q     <= used_d;
         misses_q   <= misses_d;
         g_q        <= g_d;
         go_q       <= go_d;
         guess_q    <= guess_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         dup_q      <= dup_d;
         invalid_q  <= invalid_d;
         won_q      <= won_d;
         lost_q     <= lost_d;
      end
   end

   // go and guess pass through one input register, so the FSM sees a guess one edge after it arrives.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      active_d   = active_q;
      revealed_d = revealed_q;
      used_d     = used_q;
      misses_d   = misses_q;
      g_d        = g_q;
      go_d       = go;
      guess_d    = guess;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      dup_d      = 1'b0;
      invalid_d  = 1'b0;
      won_d      = won_q;
      lost_d     = lost_q;

      if (start) begin
         word_d     = word_in;
         active_d   = word_active;
         revealed_d = '0;
         used_d     = '0;
         misses_d   = '0;
         lost_d     = 1'b0;
         won_d      = (word_active == '0);
         state_d    = S_RELEASE;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_READY: begin
               if (go_q) begin
                  g_d     = guess_q;
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               state_d = S_RELEASE;
               if (g_q > LAST_CODE) begin
                  invalid_d = 1'b1;
               end else if (used_q[g_q]) begin
                  dup_d = 1'b1;
               end else if (match != '0) begin
                  revealed_d  = revealed_q | match;
                  used_d[g_q] = 1'b1;
                  hit_d       = 1'b1;
                  if ((revealed_q | match) == active_q) won_d = 1'b1;
               end else begin
                  used_d[g_q] = 1'b1;
                  miss_d      = 1'b1;
                  if (misses_q < MISS_LIMIT) begin
                     misses_d = misses_q + MISS_ONE;
                     if (misses_q + MISS_ONE == MISS_LIMIT) lost_d = 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (!go_q) state_d = (won_q | lost_q) ? S_DONE : S_READY;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ready    = (state_q == S_READY);
      revealed = revealed_q;
      active   = active_q;
      misses   = misses_q;
      hit      = hit_q;
      miss     = miss_q;
      dup      = dup_q;
      invalid  = invalid_q;
      won      = won_q;
      lost     = lost_q;
   end

endmodule

// File: tb/tb_guess_engine.sv
// Scenario bench for guess_engine with a letter-level game model and randomized games.
module tb_guess_engine;

   localparam int ML = 5;
   localparam int LW = 5;
   localparam int MM = 6;
   localparam int MW = $clog2(MM + 1);

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic [ML*LW-1:0] word_in = '0;
   logic             go = 1'b0;
   logic [LW-1:0]    guess = '0;
   logic [ML-1:0]    revealed, active;
   logic [MW-1:0]    misses;
   logic             hit, miss, dup, invalid, won, lost, ready;

   guess_engine #(.MAX_LEN(ML), .LETTER_W(LW), .MAX_MISSES(MM)) dut (
      .clk(clk), .resetn(resetn), .start(start), .word_in(word_in),
      .go(go), .guess(guess), .revealed(revealed), .active(active),
      .misses(misses), .hit(hit), .miss(miss), .dup(dup), .invalid(invalid),
      .won(won), .lost(lost), .ready(ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Game model: letters per slot (31 = blank), revealed slots, used letters, miss count.
   int m_word[ML];
   bit m_rev[ML];
   bit m_used[26];
   int m_miss;
   bit m_won, m_lost;

   function automatic logic [ML-1:0] exp_active();
      logic [ML-1:0] v = '0;
      for (int i = 0; i < ML; i++) v[i] = (m_word[i] != 31);
      return v;
   endfunction

   function automatic logic [ML-1:0] exp_revealed();
      logic [ML-1:0] v = '0;
      for (int i = 0; i < ML; i++) v[i] = m_rev[i];
      return v;
   endfunction

   function automatic logic [3:0] pulses();
      return {hit, miss, dup, invalid};
   endfunction

   task automatic set_stay();
      m_word[0] = 18; m_word[1] = 19; m_word[2] = 0; m_word[3] = 24; m_word[4] = 31;
   endtask

   task automatic check_state(input string tag);
      n_vec++;
      if (revealed !== exp_revealed() || misses !== MW'(m_miss) || won !== m_won || lost !== m_lost) begin
         n_err++;
         $display("FAIL %s: revealed=%b misses=%0d won=%b lost=%b, required revealed=%b misses=%0d won=%b lost=%b",
                  tag, revealed, misses, won, lost, exp_revealed(), m_miss, m_won, m_lost);
      end
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 30; i++) begin
         if (ready === 1'b1) break;
         @(negedge clk);
      end
      n_vec++;
      if (ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s_ready_timeout: ready=%b, required 1", tag, ready);
      end
   endtask

   task automatic start_game(input string tag);
      for (int i = 0; i < ML; i++) begin
         word_in[i*LW +: LW] = LW'(m_word[i]);
         m_rev[i] = 1'b0;
      end
      for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
      m_miss = 0;
      m_lost = 1'b0;
      m_won  = (exp_active() == '0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      $display("start %s word=%h active=%b won=%b", tag, word_in, active, won);
      n_vec++;
      if (active !== exp_active()) begin
         n_err++;
         $display("FAIL %s_active: active=%b, required %b", tag, active, exp_active());
      end
      check_state({tag, "_load"});
      if (!m_won) wait_ready(tag);
      else repeat (3) @(negedge clk);
   endtask

   // Applies one guess from S_READY at a negedge and checks the T+2 result.
   task automatic do_guess(input int letter, input string tag);
      logic [3:0] exp_p;
      bit any;
      if (letter > 25) exp_p = 4'b0001;
      else if (m_used[letter]) exp_p = 4'b0010;
      else begin
         m_used[letter] = 1'b1;
         any = 1'b0;
         for (int i = 0; i < ML; i++)
            if (m_word[i] == letter) begin m_rev[i] = 1'b1; any = 1'b1; end
         if (any) begin
            exp_p = 4'b1000;
            m_won = 1'b1;
            for (int i = 0; i < ML; i++)
               if (m_word[i] != 31 && !m_rev[i]) m_won = 1'b0;
         end else begin
            exp_p = 4'b0100;
            if (m_miss < MM) m_miss++;
            if (m_miss == MM) m_lost = 1'b1;
         end
      end
      guess = LW'(letter);
      go = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (pulses() !== 4'b0000) begin
         n_err++;
         $display("FAIL %s_early: pulses=%b, required 0000 before T+2", tag, pulses());
      end
      @(negedge clk);
      $display("guess %s letter=%0d pulses(h,m,d,i)=%b revealed=%b misses=%0d won=%b lost=%b",
               tag, letter, pulses(), revealed, misses, won, lost);
      n_vec++;
      if (pulses() !== exp_p) begin
         n_err++;
         $display("FAIL %s_pulse: pulses=%b, required %b", tag, pulses(), exp_p);
      end
      check_state(tag);
      @(negedge clk);
      n_vec++;
      if (pulses() !== 4'b0000) begin
         n_err++;
         $display("FAIL %s_pulse_len: pulses=%b, required 0000", tag, pulses());
      end
      go = 1'b0;
      if (m_won || m_lost) repeat (3) @(negedge clk);
      else wait_ready(tag);
   endtask

   task automatic test_done_ignores(input string tag);
      int cnt = 0;
      guess = LW'($urandom_range(0, 25));
      go = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (pulses() != 4'b0000) cnt++;
      end
      go = 1'b0;
      repeat (2) @(negedge clk);
      $display("done_go %s pulses_seen=%0d ready=%b", tag, cnt, ready);
      n_vec++;
      if (cnt !== 0 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s_done: pulses_seen=%0d ready=%b, required 0 and 0", tag, cnt, ready);
      end
      check_state({tag, "_done_hold"});
   endtask

   task automatic check_all_zero(input string tag);
      n_vec++;
      if ({revealed, active, misses, hit, miss, dup, invalid, won, lost, ready} !== '0) begin
         n_err++;
         $display("FAIL %s: revealed=%b active=%b misses=%0d pulses=%b won=%b lost=%b ready=%b, required all 0",
                  tag, revealed, active, misses, pulses(), won, lost, ready);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset_held");
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      $display("reset released ready=%b", ready);
      check_all_zero("reset_idle");
   endtask

   task automatic test_hit();
      set_stay();
      start_game("stay");
      do_guess(19, "hit_T");
   endtask

   task automatic test_miss_dup();
      do_guess(16, "miss_Q");
      do_guess(16, "dup_Q");
      do_guess(19, "dup_T");
   endtask

   task automatic test_win();
      do_guess(18, "hit_S");
      do_guess(0,  "hit_A");
      do_guess(24, "win_Y");
      test_done_ignores("win");
   endtask

   task automatic test_loss();
      set_stay();
      start_game("stay_loss");
      for (int l = 1; l <= 6; l++) do_guess(l, "loss_step");
      test_done_ignores("loss");
   endtask

   task automatic test_invalid_hold();
      int cnt = 0;
      set_stay();
      start_game("stay_inv");
      do_guess(31, "invalid_31");
      guess = LW'(18);
      go = 1'b1;
      m_used[18] = 1'b1;
      m_rev[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pulses() != 4'b0000) cnt++;
      end
      $display("hold_go letter=18 pulses_seen=%0d revealed=%b", cnt, revealed);
      n_vec++;
      if (cnt !== 1) begin
         n_err++;
         $display("FAIL hold_go_once: pulses_seen=%0d, required 1", cnt);
      end
      check_state("hold_go_state");
      go = 1'b0;
      wait_ready("hold_go");
      // start while go held: reload then no guess until go drops
      cnt = 0;
      guess = LW'(0);
      go = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < ML; i++) m_rev[i] = 1'b0;
      for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
      m_miss = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pulses() != 4'b0000 || ready) cnt++;
      end
      $display("start_with_go cycles_with_activity=%0d", cnt);
      n_vec++;
      if (cnt !== 0) begin
         n_err++;
         $display("FAIL start_go_held: active_cycles=%0d, required 0", cnt);
      end
      check_state("start_go_held_state");
      go = 1'b0;
      wait_ready("start_go_release");
      do_guess(0, "after_start_A");
   endtask

   task automatic test_async_reset();
      set_stay();
      start_game("stay_rst");
      do_guess(19, "pre_rst_T");
      guess = LW'(18);
      go = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      $display("async reset in check revealed=%b active=%b", revealed, active);
      check_all_zero("async_reset");
      go = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_all_zero("after_async_reset");
   endtask

   task automatic test_empty();
      for (int i = 0; i < ML; i++) m_word[i] = 31;
      start_game("empty");
      n_vec++;
      if (won !== 1'b1) begin
         n_err++;
         $display("FAIL empty_won: won=%b, required 1", won);
      end
      test_done_ignores("empty");
   endtask

   task automatic test_random();
      int letter;
      for (int gm = 0; gm < 10; gm++) begin
         for (int i = 0; i < ML; i++)
            m_word[i] = ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 25));
         start_game("rand");
         for (int k = 0; k < 60 && !m_won && !m_lost; k++) begin
            if ($urandom_range(0, 9) < 5) letter = m_word[$urandom_range(0, ML - 1)];
            else letter = int'($urandom_range(0, 31));
            do_guess(letter, "rand");
         end
         if (m_won || m_lost) test_done_ignores("rand");
      end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss_dup();
      test_win();
      test_loss();
      test_invalid_hold();
      test_async_reset();
      test_empty();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
